seq_restoring_divider: RTL and testbench

//  Multi-cycle unsigned restoring divider. It is the inverse arithmetic

---
 rtl/seq_restoring_divider.sv | 176 +++++++++++++++++
 tb/tb_seq_restoring_divider.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_restoring_divider.sv
// Multi-cycle unsigned restoring divider: one quotient bit per clock.
// The trial subtract R_sh - D is formed as R_sh + ~D + 1 using 4-bit
// carry-lookahead slices; the final carry-out is the "no borrow" flag.
//
// Ports:
//   Clk        system clock, rising edge
//   Reset_n    synchronous active-low reset
//   Start      request, sampled only while Ready=1
//   Dividend   unsigned numerator, captured on accepted Start
//   Divisor    unsigned denominator, captured on accepted Start
//   Ready      high only in IDLE
//   Done       one-cycle pulse; results valid from this cycle
//   Quotient   registered quotient, held until next Done
//   Remainder  registered remainder, held until next Done
//   DivByZero  registered divide-by-zero flag for last operation
module seq_restoring_divider #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             Clk,
    input  logic             Reset_n,
    input  logic             Start,
    input  logic [WIDTH-1:0] Dividend,
    input  logic [WIDTH-1:0] Divisor,
    output logic             Ready,
    output logic             Done,
    output logic [WIDTH-1:0] Quotient,
    output logic [WIDTH-1:0] Remainder,
    output logic             DivByZero
);

    localparam int unsigned NSLICE = WIDTH / 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic             accept;
    logic             accept_dbz;
    logic             finish;

    // Partial remainder is always < divisor, so its extra trial bit is
    // provably zero between iterations and only the shifted value needs it.
    logic [WIDTH-1:0] r_reg;
    logic [WIDTH-1:0] q_reg;
    logic [WIDTH-1:0] d_reg;
    logic [CNT_W-1:0] cnt;

    logic [WIDTH:0]   r_sh;
    logic [WIDTH:0]   sub_b;
    logic [WIDTH-1:0] diff;
    logic [NSLICE:0]  c_slice;
    logic             no_borrow;
    logic [WIDTH-1:0] r_nxt;
    logic [WIDTH-1:0] q_nxt;

    // 4-bit carry-lookahead slice: returns {carry_out, sum[3:0]}.
    function automatic logic [4:0] cla4(input logic [3:0] a, input logic [3:0] b,
                                        input logic cin);
        logic [3:0] g;
        logic [3:0] p;
        logic [4:0] c;
        g    = a & b;
        p    = a ^ b;
        c[0] = cin;
        c[1] = g[0] | (p[0] & cin);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
        c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
             | (p[3] & p[2] & p[1] & p[0] & cin);
        return {c[4], p ^ c[3:0]};
    endfunction

    // Shift {R,Q} left by one and form the trial subtract operands.
    assign r_sh       = {1'b0, r_reg[WIDTH-1:0], q_reg[WIDTH-1]} >> 0;
    assign sub_b      = ~{1'b0, d_reg};
    assign c_slice[0] = 1'b1;

    for (genvar gi = 0; gi < NSLICE; gi++) begin : g_slice
        assign {c_slice[gi+1], diff[4*gi+3:4*gi]} =
            cla4(r_sh[4*gi+3:4*gi], sub_b[4*gi+3:4*gi], c_slice[gi]);
    end

    // Extra top bit of the WIDTH+1-bit subtract; carry-out means T >= 0.
    assign no_borrow = (r_sh[WIDTH] & sub_b[WIDTH])
                     | ((r_sh[WIDTH] ^ sub_b[WIDTH]) & c_slice[NSLICE]);

    assign r_nxt = no_borrow ? diff : r_sh[WIDTH-1:0];
    assign q_nxt = {q_reg[WIDTH-2:0], no_borrow};

    // State register.
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and control strobes.
    always_comb begin
        state_nxt  = state;
        accept     = 1'b0;
        accept_dbz = 1'b0;
        finish     = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (Start) begin
                    if (Divisor == '0) begin
                        accept_dbz = 1'b1;
                        state_nxt  = ST_DONE;
                    end else begin
                        accept    = 1'b1;
                        state_nxt = ST_RUN;
                    end
                end
            end
            ST_RUN: begin
                if (cnt == CNT_W'(WIDTH - 1)) begin
                    finish    = 1'b1;
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Datapath, result and handshake registers.
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            r_reg     <= '0;
            q_reg     <= '0;
            d_reg     <= '0;
            cnt       <= '0;
            Quotient  <= '0;
            Remainder <= '0;
            DivByZero <= 1'b0;
            Ready     <= 1'b1;
            Done      <= 1'b0;
        end else begin
            Ready <= (state_nxt == ST_IDLE);
            Done  <= (state_nxt == ST_DONE);
            if (accept) begin
                d_reg <= Divisor;
                q_reg <= Dividend;
                r_reg <= '0;
                cnt   <= '0;
            end
            if (accept_dbz) begin
                Quotient  <= '1;
                Remainder <= Dividend;
                DivByZero <= 1'b1;
            end
            if (state == ST_RUN) begin
                r_reg <= r_nxt;
                q_reg <= q_nxt;
                cnt   <= cnt + CNT_W'(1);
            end
            if (finish) begin
                Quotient  <= q_nxt;
                Remainder <= r_nxt;
                DivByZero <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_seq_restoring_divider.sv
// Self-checking bench for seq_restoring_divider (WIDTH=8).
// Expected results are queued when an operation is issued and compared
// by a monitor whenever Done pulses.
module tb_seq_restoring_divider;

    localparam int unsigned WIDTH = 8;

    logic             clk;
    logic             reset_n;
    logic             start;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             ready;
    logic             done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_by_zero;

    typedef struct {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [WIDTH-1:0] q;
        logic [WIDTH-1:0] r;
        logic             dbz;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   n_done   = 0;
    int   cyc      = 0;

    seq_restoring_divider #(.WIDTH(WIDTH)) dut (
        .Clk       (clk),
        .Reset_n   (reset_n),
        .Start     (start),
        .Dividend  (dividend),
        .Divisor   (divisor),
        .Ready     (ready),
        .Done      (done),
        .Quotient  (quotient),
        .Remainder (remainder),
        .DivByZero (div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Scoreboard monitor: compare results and invariants on every Done.
    always @(negedge clk) begin
        exp_t e;
        if (done) begin
            n_done++;
            if (sb.size() == 0) begin
                check("unexpected_done", 32'(1), 32'(0));
            end else begin
                e = sb.pop_front();
                check("quotient", 32'(quotient), 32'(e.q));
                check("remainder", 32'(remainder), 32'(e.r));
                check("div_by_zero", 32'(div_by_zero), 32'(e.dbz));
                if (!e.dbz) begin
                    check("inv_product", 32'(quotient) * 32'(e.b) + 32'(remainder), 32'(e.a));
                    check("inv_rem_lt_div", 32'(remainder < e.b), 32'(1));
                end
            end
        end
    end

    function automatic exp_t model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        exp_t e;
        e.a = a;
        e.b = b;
        if (b == '0) begin
            e.q   = '1;
            e.r   = a;
            e.dbz = 1'b1;
        end else begin
            e.q   = a / b;
            e.r   = a % b;
            e.dbz = 1'b0;
        end
        return e;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready();
        int k = 0;
        while (!ready && k < 64) begin
            step();
            k++;
        end
        if (!ready) check("ready_timeout", 32'(ready), 32'(1));
    endtask

    // Drive one Start pulse; returns just after the accepting edge.
    task automatic start_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                            input bit push);
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        if (push) sb.push_back(model(a, b));
        step();
        start = 1'b0;
    endtask

    // Count edges from now until Done is observed (bounded).
    task automatic wait_done(output int n);
        n = 0;
        while (!done && n < 64) begin
            step();
            n++;
        end
    endtask

    task automatic do_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        int n;
        wait_ready();
        start_op(a, b, 1'b1);
        wait_done(n);
        check("latency", 32'(n), (b == '0) ? 32'(0) : 32'(WIDTH));
    endtask

    initial begin
        int          n;
        int          prev_cyc;
        int          done_before;
        logic [WIDTH-1:0] a6 [3];
        logic [WIDTH-1:0] b6 [3];
        logic [WIDTH-1:0] ra;
        logic [WIDTH-1:0] rb;

        reset_n  = 1'b0;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        prev_cyc = 0;
        a6[0] = 8'd100; b6[0] = 8'd3;
        a6[1] = 8'd9;   b6[1] = 8'd9;
        a6[2] = 8'd0;   b6[2] = 8'd5;

        // Reset state
        step();
        step();
        check("rst_ready", 32'(ready), 32'(1));
        check("rst_done", 32'(done), 32'(0));
        check("rst_quotient", 32'(quotient), 32'(0));
        check("rst_remainder", 32'(remainder), 32'(0));
        check("rst_dbz", 32'(div_by_zero), 32'(0));
        reset_n = 1'b1;
        step();

        // Basic and boundary divisions
        do_op(8'd200, 8'd7);
        do_op(8'd255, 8'd1);
        do_op(8'd5, 8'd9);
        do_op(8'd255, 8'd255);
        do_op(8'd77, 8'd0);

        // Start mid-RUN is ignored; previous results held during RUN
        wait_ready();
        start_op(8'd123, 8'd10, 1'b1);
        step();
        step();
        start    = 1'b1;
        dividend = 8'd13;
        divisor  = 8'd2;
        check("ready_mid_run", 32'(ready), 32'(0));
        step();
        start = 1'b0;
        check("ready_mid_run2", 32'(ready), 32'(0));
        check("held_quotient", 32'(quotient), 32'(8'hFF));
        check("held_dbz", 32'(div_by_zero), 32'(1));
        wait_done(n);
        check("latency_ignored_start", 32'(n), 32'(WIDTH - 3));
        check("ready_in_done", 32'(ready), 32'(0));
        step();
        check("ready_after_done", 32'(ready), 32'(1));
        check("done_one_cycle", 32'(done), 32'(0));

        // Reset mid-RUN aborts without Done
        start_op(8'd50, 8'd3, 1'b0);
        step();
        step();
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
        check("abort_quotient", 32'(quotient), 32'(0));
        check("abort_remainder", 32'(remainder), 32'(0));
        check("abort_dbz", 32'(div_by_zero), 32'(0));
        check("abort_ready", 32'(ready), 32'(1));
        check("abort_done", 32'(done), 32'(0));
        done_before = n_done;
        repeat (WIDTH + 4) step();
        check("abort_no_done", 32'(n_done), 32'(done_before));
        do_op(8'd45, 8'd6);

        // Start held high: back-to-back operations
        wait_ready();
        for (int i = 0; i < 3; i++) begin
            dividend = a6[i];
            divisor  = b6[i];
            start    = 1'b1;
            sb.push_back(model(a6[i], b6[i]));
            step();
            wait_done(n);
            check("b2b_done_seen", 32'(done), 32'(1));
            if (i > 0) check("b2b_gap", 32'(cyc - prev_cyc), 32'(WIDTH + 2));
            prev_cyc = cyc;
        end
        start = 1'b0;

        // Random sweep
        repeat (1000) begin
            ra = WIDTH'($urandom_range(0, 255));
            rb = ($urandom_range(0, 15) == 0) ? '0 : WIDTH'($urandom_range(1, 255));
            do_op(ra, rb);
        end

        step();
        step();
        check("sb_drain", 32'(sb.size()), 32'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
